dvbc_rs_encoder: RTL and testbench

Parametrised systematic Reed-Solomon encoder for the DVB-C modulator, default RS(204,188,t=8) shortened from RS(255,239) over GF(256). It sits between the transport-stream packet framer and the convolutional interleaver. Message symbols pass through unchanged, then PAR_LEN parity symbols follow. Generator polynomial and field are parameters, so the same block serves other shortened RS codes (e.g. J.83 variants).

---
 rtl/dvbc_rs_pkg.sv | 62 ++++++
 rtl/dvbc_rs_lfsr.sv | 53 +++++
 rtl/dvbc_rs_encoder.sv | 132 +++++++++++++
 tb/tb_dvbc_rs_encoder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvbc_rs_pkg.sv
// Shared GF(2^m) arithmetic, RS generator construction and DVB-C default constants.
// Elaboration-time helpers only; no state.
package dvbc_rs_pkg;

  localparam int         DVBC_SYM_W   = 8;
  localparam logic [8:0] DVBC_GF_POLY = 9'h11D;
  localparam int         DVBC_MSG_LEN = 188;
  localparam int         DVBC_PAR_LEN = 16;
  localparam int         DVBC_FCR     = 0;

  localparam int MAX_SYM_W   = 8;
  localparam int MAX_PAR_LEN = 32;

  typedef enum logic {
    PH_MSG = 1'b0,
    PH_PAR = 1'b1
  } phase_t;

  // Shift-and-add multiply; bits above sym_w stay zero because every
  // doubling is reduced as soon as it reaches the field width.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input int sym_w, input logic [8:0] poly);
    logic [8:0] acc;
    logic [8:0] top_bit;
    logic [7:0] prod;
    acc     = {1'b0, a};
    top_bit = 9'd1 << sym_w;
    prod    = 8'd0;
    for (int i = 0; i < MAX_SYM_W; i++) begin
      if (i < sym_w) begin
        if (((b >> i) & 8'd1) != 8'd0) prod = prod ^ acc[7:0];
        acc = acc << 1;
        if ((acc & top_bit) != 9'd0) acc = acc ^ poly;
      end
    end
    return prod;
  endfunction

  // Coefficients g[0..par_len-1] of prod (x + alpha^(fcr+i)), packed 8 bits each;
  // the monic x^par_len term is implicit.
  function automatic logic [MAX_PAR_LEN*8-1:0] gen_poly(input int sym_w, input logic [8:0] poly,
                                                       input int fcr, input int par_len);
    logic [7:0]               g [MAX_PAR_LEN+1];
    logic [7:0]               root;
    logic [MAX_PAR_LEN*8-1:0] packed_g;
    for (int j = 0; j <= MAX_PAR_LEN; j++) g[j] = 8'd0;
    g[0] = 8'd1;
    root = 8'd1;
    for (int e = 0; e < fcr; e++) root = gf_mul(root, 8'd2, sym_w, poly);
    for (int i = 0; i < MAX_PAR_LEN; i++) begin
      if (i < par_len) begin
        for (int j = MAX_PAR_LEN; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root, sym_w, poly);
        g[0] = gf_mul(g[0], root, sym_w, poly);
        root = gf_mul(root, 8'd2, sym_w, poly);
      end
    end
    packed_g = '0;
    for (int j = 0; j < MAX_PAR_LEN; j++) packed_g[j*8 +: 8] = g[j];
    return packed_g;
  endfunction

endpackage

// File: rtl/dvbc_rs_lfsr.sv
// RS parity register bank: load = divide in one message symbol, shift = move parity out.
// clear restarts from an all-zero state (alone, or combined with load for the first symbol).
module dvbc_rs_lfsr
  import dvbc_rs_pkg::*;
#(
  parameter int         SYM_W   = DVBC_SYM_W,
  parameter logic [8:0] GF_POLY = DVBC_GF_POLY,
  parameter int         PAR_LEN = DVBC_PAR_LEN,
  parameter int         FCR     = DVBC_FCR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [SYM_W-1:0] din,
  output logic [SYM_W-1:0] top
);

  localparam logic [MAX_PAR_LEN*8-1:0] G = gen_poly(SYM_W, GF_POLY, FCR, PAR_LEN);

  logic [SYM_W-1:0] r     [PAR_LEN];
  logic [SYM_W-1:0] base  [PAR_LEN];
  logic [SYM_W-1:0] r_nxt [PAR_LEN];
  logic [SYM_W-1:0] fb;

  function automatic logic [SYM_W-1:0] mul_g(input logic [SYM_W-1:0] a, input int k);
    return SYM_W'(gf_mul(8'(a), G[k*8 +: 8], SYM_W, GF_POLY));
  endfunction

  always_comb begin
    for (int k = 0; k < PAR_LEN; k++) base[k] = clear ? '0 : r[k];
    fb       = din ^ base[PAR_LEN-1];
    r_nxt[0] = mul_g(fb, 0);
    for (int k = 1; k < PAR_LEN; k++) r_nxt[k] = base[k-1] ^ mul_g(fb, k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PAR_LEN; k++) r[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < PAR_LEN; k++) r[k] <= r_nxt[k];
    end else if (shift) begin
      r[0] <= '0;
      for (int k = 1; k < PAR_LEN; k++) r[k] <= r[k-1];
    end else if (clear) begin
      for (int k = 0; k < PAR_LEN; k++) r[k] <= '0;
    end
  end

  assign top = r[PAR_LEN-1];

endmodule

// File: rtl/dvbc_rs_encoder.sv
// Systematic shortened RS encoder: message passes through, PAR_LEN parity symbols follow.
// Latency 1 cycle; input stalls while parity drains or when the output register is held.
// Optional DVBC_RS_ERR_CNT_EN adds a saturating 16-bit err_cnt of framing errors.
module dvbc_rs_encoder
  import dvbc_rs_pkg::*;
#(
  parameter int         SYM_W   = DVBC_SYM_W,
  parameter logic [8:0] GF_POLY = DVBC_GF_POLY,
  parameter int         MSG_LEN = DVBC_MSG_LEN,
  parameter int         PAR_LEN = DVBC_PAR_LEN,
  parameter int         FCR     = DVBC_FCR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [SYM_W-1:0] s_data,
  input  logic             s_sop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SYM_W-1:0] m_data,
  output logic             m_sop,
  output logic             m_eop,
  output logic             m_par,
  output logic             sop_err
`ifdef DVBC_RS_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int IDX_MAX = (MSG_LEN > PAR_LEN) ? MSG_LEN : PAR_LEN;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam logic [IDX_W-1:0] MSG_LAST = IDX_W'(MSG_LEN - 1);
  localparam logic [IDX_W-1:0] PAR_LAST = IDX_W'(PAR_LEN - 1);
  localparam logic             ONE_SYM  = (MSG_LEN == 1);

  phase_t           phase;
  logic [IDX_W-1:0] idx;
  logic             out_adv;
  logic             s_fire;
  logic             at_start;
  logic             restart;
  logic             msg_last;
  logic             par_shift;
  logic [SYM_W-1:0] par_sym;

  assign out_adv   = !m_valid || m_ready;
  assign s_ready   = (phase == PH_MSG) && out_adv;
  assign s_fire    = s_valid && s_ready;
  assign at_start  = (idx == '0);
  assign restart   = s_sop && !at_start;
  // A mid-packet sop re-bases the symbol to idx 0, so "last" must be judged from there.
  assign msg_last  = restart ? ONE_SYM : (idx == MSG_LAST);
  assign par_shift = (phase == PH_PAR) && out_adv;

  dvbc_rs_lfsr #(
    .SYM_W  (SYM_W),
    .GF_POLY(GF_POLY),
    .PAR_LEN(PAR_LEN),
    .FCR    (FCR)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (s_fire),
    .shift(par_shift),
    .clear(s_fire && (at_start || s_sop)),
    .din  (s_data),
    .top  (par_sym)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= PH_MSG;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
      m_par   <= 1'b0;
      sop_err <= 1'b0;
    end else begin
      sop_err <= s_fire && (s_sop != at_start);
      case (phase)
        PH_MSG: begin
          if (s_fire) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_sop   <= at_start || s_sop;
            m_eop   <= 1'b0;
            m_par   <= 1'b0;
            if (msg_last) begin
              phase <= PH_PAR;
              idx   <= '0;
            end else begin
              idx <= restart ? IDX_W'(1) : idx + 1'b1;
            end
          end else if (out_adv) begin
            m_valid <= 1'b0;
          end
        end
        PH_PAR: begin
          if (out_adv) begin
            m_valid <= 1'b1;
            m_data  <= par_sym;
            m_sop   <= 1'b0;
            m_par   <= 1'b1;
            m_eop   <= (idx == PAR_LAST);
            if (idx == PAR_LAST) begin
              phase <= PH_MSG;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: phase <= PH_MSG;
      endcase
    end
  end

`ifdef DVBC_RS_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (sop_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dvbc_rs_encoder.sv
// Self-checking bench for dvbc_rs_encoder (default DVB-C RS(204,188)); reference uses
// log/antilog GF tables and polynomial long division over whole codewords.
module tb_dvbc_rs_encoder;
  import dvbc_rs_pkg::*;

  localparam int ML = 188;
  localparam int PL = 16;
  localparam int CL = ML + PL;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       par;
    logic [7:0] dat;
  } osym_t;

  typedef struct {
    int           kind;
    int           val;
    logic         sop_first;
    int           exp_err;
    logic [127:0] exp_par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_ready, s_sop;
  logic [7:0] s_data;
  logic       m_valid, m_ready, m_sop, m_eop, m_par, sop_err;
  logic [7:0] m_data;
`ifdef DVBC_RS_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  dvbc_rs_encoder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_sop  (s_sop),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_sop  (m_sop),
    .m_eop  (m_eop),
    .m_par  (m_par),
    .sop_err(sop_err)
`ifdef DVBC_RS_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- GF reference (log tables) ----------------
  int alog [511];
  int lg   [256];
  int gb   [17];

  function automatic void build_tables();
    int x;
    x = 1;
    lg[0] = 0;
    for (int i = 0; i < 255; i++) begin
      alog[i]       = x;
      alog[i + 255] = x;
      lg[x]         = i;
      x             = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    alog[510] = alog[0];
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[lg[a] + lg[b]];
  endfunction

  function automatic void build_gen();
    for (int j = 0; j <= PL; j++) gb[j] = 0;
    gb[0] = 1;
    for (int i = 0; i < PL; i++) begin
      for (int j = PL; j >= 1; j--) gb[j] = gb[j-1] ^ gmul(gb[j], alog[i]);
      gb[0] = gmul(gb[0], alog[i]);
    end
  endfunction

  // Remainder of m(x)*x^PL divided by g(x); first transmitted symbol is the top degree.
  function automatic void encode(input int msg[ML], output int par[PL]);
    int w[CL];
    int q;
    for (int n = 0; n < CL; n++) w[n] = (n < ML) ? msg[n] : 0;
    for (int n = 0; n < ML; n++) begin
      q = w[n];
      if (q != 0)
        for (int j = 0; j <= PL; j++) w[n + j] = w[n + j] ^ gmul(q, gb[PL - j]);
    end
    for (int k = 0; k < PL; k++) par[k] = w[ML + k];
  endfunction

  function automatic int syndromes_bad(input int cw[CL]);
    int s;
    for (int i = 0; i < PL; i++) begin
      s = 0;
      for (int n = 0; n < CL; n++) s = gmul(s, alog[i]) ^ cw[n];
      if (s != 0) return 1;
    end
    return 0;
  endfunction

  // ---------------- stream capture ----------------
  osym_t got_q[$];
  osym_t exp_q[$];
  osym_t mon_cur, held;
  logic  held_v = 1'b0;
  int    stab_err = 0;
  int    low_cnt = 0;
  logic  low_en = 1'b0;
  int    err_seen = 0;
  logic  rdy_mode = 1'b0;
  logic  gap_en = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      mon_cur = osym_t'({m_sop, m_eop, m_par, m_data});
      if (held_v && (!m_valid || mon_cur != held)) stab_err++;
      held_v = m_valid && !m_ready;
      held   = mon_cur;
      if (m_valid && m_ready) got_q.push_back(mon_cur);
      if (low_en && !s_ready) low_cnt++;
      if (sop_err) err_seen++;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) m_ready = ~m_ready;
      else m_ready = 1'b1;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers / helpers ----------------
  task automatic put_sym(input logic [7:0] d, input logic sop);
    int guard;
    guard = 0;
    if (gap_en && $urandom_range(0, 2) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_sop   = sop;
    @(negedge clk);
    while (!s_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      n_chk++;
      n_fail++;
      $display("FAIL put_sym_timeout: s_ready low for %0d cycles, expected acceptance", guard);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sop   = 1'b0;
  endtask

  task automatic send_msg(input int msg[ML], input int first, input int last, input logic sop_first);
    for (int n = first; n <= last; n++) put_sym(8'(msg[n]), (n == 0) && sop_first);
  endtask

  task automatic push_codeword(input int msg[ML]);
    int par[PL];
    encode(msg, par);
    for (int n = 0; n < ML; n++) exp_q.push_back(osym_t'({n == 0, 1'b0, 1'b0, 8'(msg[n])}));
    for (int k = 0; k < PL; k++) exp_q.push_back(osym_t'({1'b0, k == PL - 1, 1'b1, 8'(par[k])}));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // One comparison per codeword segment plus a syndrome check on each full codeword.
  task automatic compare_stream(input string nm);
    int seg_start;
    int bad;
    int cw[CL];
    seg_start = 0;
    bad       = -1;
    check({nm, "_len"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bad < 0 && (i >= got_q.size() || got_q[i] != exp_q[i])) bad = i;
      if (exp_q[i].eop || i == exp_q.size() - 1 || exp_q[i+1].sop) begin
        n_chk++;
        if (bad >= 0) begin
          n_fail++;
          if (bad < got_q.size())
            $display("FAIL %s_seg@%0d: symbol %0d got %0h, expected %0h", nm, seg_start, bad,
                     got_q[bad], exp_q[bad]);
          else
            $display("FAIL %s_seg@%0d: symbol %0d missing, expected %0h", nm, seg_start, bad,
                     exp_q[bad]);
        end
        if (exp_q[i].eop && (i - seg_start + 1) == CL && i < got_q.size()) begin
          for (int n = 0; n < CL; n++) cw[n] = int'(got_q[seg_start + n].dat);
          check($sformatf("%s_syndrome@%0d", nm, seg_start), 128'(syndromes_bad(cw)), 128'(0));
        end
        seg_start = i + 1;
        bad       = -1;
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic void make_msg(input int kind, input int val, output int msg[ML]);
    for (int n = 0; n < ML; n++) begin
      case (kind)
        0:       msg[n] = val & 255;
        1:       msg[n] = (n == ML - 1) ? (val & 255) : 0;
        default: msg[n] = (val + n) & 255;
      endcase
    end
  endfunction

  // ---------------- test sequence ----------------
  vec_t         vt[6];
  int           msg[ML];
  int           msg_b[ML];
  int           par[PL];
  int           e0;
  int           err_exp;
  logic [127:0] got_par;
  logic [255:0] pkg_g;
  logic [127:0] tb_g;

  initial begin
    build_tables();
    build_gen();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    s_sop   = 1'b0;
    err_exp = 0;

    vt[0] = '{kind: 0, val: 8'h00, sop_first: 1'b1, exp_err: 0, exp_par: '0};
    vt[1] = '{kind: 1, val: 8'h01, sop_first: 1'b1, exp_err: 0, exp_par: '0};
    vt[2] = '{kind: 1, val: 8'h80, sop_first: 1'b1, exp_err: 0, exp_par: '0};
    vt[3] = '{kind: 0, val: 8'hFF, sop_first: 1'b1, exp_err: 0, exp_par: '0};
    vt[4] = '{kind: 2, val: 8'h10, sop_first: 1'b1, exp_err: 0, exp_par: '0};
    vt[5] = '{kind: 2, val: 8'h33, sop_first: 1'b0, exp_err: 1, exp_par: '0};
    for (int k = 0; k < PL; k++) vt[1].exp_par[k*8 +: 8] = 8'(gb[PL - 1 - k]);
    for (int r = 2; r < 6; r++) begin
      make_msg(vt[r].kind, vt[r].val, msg);
      encode(msg, par);
      for (int k = 0; k < PL; k++) vt[r].exp_par[k*8 +: 8] = 8'(par[k]);
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_m_data", 128'(m_data), 128'(0));
    check("rst_m_sop", 128'(m_sop), 128'(0));
    check("rst_m_eop", 128'(m_eop), 128'(0));
    check("rst_m_par", 128'(m_par), 128'(0));
    check("rst_sop_err", 128'(sop_err), 128'(0));
    check("rst_s_ready", 128'(s_ready), 128'(1));
`ifdef DVBC_RS_ERR_CNT_EN
    check("rst_err_cnt", 128'(err_cnt), 128'(0));
`endif
    @(posedge clk);
    #1;

    pkg_g = gen_poly(8, 9'h11D, 0, 16);
    tb_g  = '0;
    for (int k = 0; k < PL; k++) tb_g[k*8 +: 8] = 8'(gb[k]);
    check("generator_coeffs", pkg_g[127:0], tb_g);

    // Directed vectors
    for (int r = 0; r < 6; r++) begin
      make_msg(vt[r].kind, vt[r].val, msg);
      e0 = err_seen;
      push_codeword(msg);
      send_msg(msg, 0, ML - 1, vt[r].sop_first);
      wait_drain();
      got_par = '0;
      if (got_q.size() >= CL)
        for (int k = 0; k < PL; k++) got_par[k*8 +: 8] = got_q[ML + k].dat;
      check($sformatf("vec%0d_parity", r), got_par, vt[r].exp_par);
      check($sformatf("vec%0d_sop_err", r), 128'(err_seen - e0), 128'(vt[r].exp_err));
      err_exp += vt[r].exp_err;
      compare_stream($sformatf("vec%0d", r));
    end

    // Random back-to-back packets; s_ready must drop exactly PL cycles per codeword
    low_cnt = 0;
    low_en  = 1'b1;
    for (int p = 0; p < 100; p++) begin
      for (int n = 0; n < ML; n++) msg[n] = int'($urandom_range(0, 255));
      push_codeword(msg);
      send_msg(msg, 0, ML - 1, 1'b1);
    end
    wait_drain();
    low_en = 1'b0;
    check("rand_s_ready_low_cycles", 128'(low_cnt), 128'(100 * PL));
    compare_stream("rand");

    // Output stalls 1,0,1,0 plus input gaps
    rdy_mode = 1'b1;
    gap_en   = 1'b1;
    stab_err = 0;
    for (int p = 0; p < 30; p++) begin
      for (int n = 0; n < ML; n++) msg[n] = int'($urandom_range(0, 255));
      push_codeword(msg);
      send_msg(msg, 0, ML - 1, 1'b1);
    end
    wait_drain();
    rdy_mode = 1'b0;
    gap_en   = 1'b0;
    check("stall_hold_stable", 128'(stab_err), 128'(0));
    compare_stream("stall");

    // Packet abandoned by an early sop at idx 100
    for (int n = 0; n < ML; n++) msg[n] = int'($urandom_range(0, 255));
    for (int n = 0; n < ML; n++) msg_b[n] = int'($urandom_range(0, 255));
    e0 = err_seen;
    for (int n = 0; n < 100; n++) exp_q.push_back(osym_t'({n == 0, 1'b0, 1'b0, 8'(msg[n])}));
    push_codeword(msg_b);
    send_msg(msg, 0, 99, 1'b1);
    put_sym(8'(msg_b[0]), 1'b1);
    @(negedge clk);
    check("early_sop_err_pulse", 128'(sop_err), 128'(1));
    @(posedge clk);
    #1;
    send_msg(msg_b, 1, ML - 1, 1'b1);
    wait_drain();
    check("early_sop_err_count", 128'(err_seen - e0), 128'(1));
    err_exp += 1;
    compare_stream("early_sop");
`ifdef DVBC_RS_ERR_CNT_EN
    check("err_cnt_total", 128'(err_cnt), 128'(err_exp));
`endif

    // Reset asserted while parity index 5 is pending
    for (int n = 0; n < ML; n++) msg[n] = int'($urandom_range(0, 255));
    send_msg(msg, 0, ML - 1, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    check("midrst_before_m_par", 128'(m_par), 128'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 128'(m_valid), 128'(0));
    check("midrst_m_data", 128'(m_data), 128'(0));
    check("midrst_m_flags", 128'({m_sop, m_eop, m_par, sop_err}), 128'(0));
    check("midrst_s_ready", 128'(s_ready), 128'(1));
`ifdef DVBC_RS_ERR_CNT_EN
    check("midrst_err_cnt", 128'(err_cnt), 128'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    make_msg(0, 0, msg);
    push_codeword(msg);
    send_msg(msg, 0, ML - 1, 1'b1);
    wait_drain();
    got_par = '1;
    if (got_q.size() >= CL)
      for (int k = 0; k < PL; k++) got_par[k*8 +: 8] = got_q[ML + k].dat;
    check("post_rst_zero_parity", got_par, 128'(0));
    compare_stream("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
